// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_seq
// Summary  : Command sequencer feeding the LCD image controller. Commands are
//            loaded into a circular FIFO, then issued one strobe at a time,
//            paced against the controller's busy flag, ending on write (0).
// Options  : LCD_CMD_SEQ_AUTO_WRITE_EN - when the FIFO runs dry after at
//            least one command was issued, issue a synthetic write command.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       in_cmd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             start,
  input  logic             busy,
  input  logic             done,
  output logic [3:0]       cmd,
  output logic             cmd_valid,
  output logic             seq_done,
  output logic             err_badcmd,
  output logic [CNT_W-1:0] issued_cnt
);

  // Highest opcode the controller understands; anything above is rejected.
  localparam logic [3:0]  c_max_cmd   = 4'd11;
  localparam logic [3:0]  c_write_cmd = 4'd0;
  // Pointer XOR pattern meaning "same slot, different lap" (FIFO full).
  localparam logic [AW:0] c_full_xor  = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_WAIT_RDY  = 3'd1,
    S_ISSUE     = 3'd2,
    S_GAP       = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_enq_fire;
  logic             w_enq;
  logic             w_deq;
  logic [3:0]       w_head;

  logic [3:0]       r_cmd;
  logic [3:0]       w_cmd_nxt;
  logic             r_cmd_valid;
  logic             w_cmd_valid_nxt;
  logic             w_cnt_inc;
  logic             r_err_badcmd;
  logic [CNT_W-1:0] r_issued_cnt;

  // FIFO status derived from the registered pointers only.
  assign w_full     = ((r_wr_ptr ^ r_rd_ptr) == c_full_xor);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign in_ready   = !w_full && (r_state != S_DONE);
  assign w_enq_fire = in_valid && in_ready;
  assign w_enq      = w_enq_fire && (in_cmd <= c_max_cmd);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  assign cmd        = r_cmd;
  assign cmd_valid  = r_cmd_valid;
  assign seq_done   = (r_state == S_DONE);
  assign err_badcmd = r_err_badcmd;
  assign issued_cnt = r_issued_cnt;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_cmd;
    end
  end

  // FIFO pointers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the values the output registers load at this edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_deq           = 1'b0;
    w_cmd_nxt       = c_write_cmd;
    w_cmd_valid_nxt = 1'b0;
    w_cnt_inc       = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (start) begin
          w_state_nxt = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (!busy) begin
          if (!w_empty) begin
            w_state_nxt     = S_ISSUE;
            w_cmd_nxt       = w_head;
            w_cmd_valid_nxt = 1'b1;
            w_deq           = 1'b1;
            w_cnt_inc       = 1'b1;
          end
`ifdef LCD_CMD_SEQ_AUTO_WRITE_EN
          else if (r_issued_cnt != '0) begin
            // Queue ran dry mid-sequence: close it with a write command.
            w_state_nxt     = S_ISSUE;
            w_cmd_nxt       = c_write_cmd;
            w_cmd_valid_nxt = 1'b1;
            w_cnt_inc       = 1'b1;
          end
`endif
        end
      end
      S_ISSUE: begin
        // r_cmd holds the command strobed this cycle.
        if (r_cmd == c_write_cmd) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // Gives the controller a cycle to raise busy for the previous command.
        w_state_nxt = S_WAIT_RDY;
      end
      S_WAIT_DONE: begin
        if (done) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // Registered command outputs; cmd idles at 0 whenever no strobe is present.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd       <= c_write_cmd;
      r_cmd_valid <= 1'b0;
    end else begin
      r_cmd       <= w_cmd_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
    end
  end

  // Saturating count of issued commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issued_cnt <= '0;
    end else if (w_cnt_inc && (r_issued_cnt != {CNT_W{1'b1}})) begin
      r_issued_cnt <= r_issued_cnt + 1'b1;
    end
  end

  // Sticky flag for rejected opcodes offered to the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_badcmd <= 1'b0;
    end else if (w_enq_fire && (in_cmd > c_max_cmd)) begin
      r_err_badcmd <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Command sequencer directly upstream of the LCD image controller; drives its cmd/cmd_valid inputs.
- A host or testbench loads a command list into an internal FIFO, then pulses start.
- The sequencer paces commands against the controller's busy signal and ends on the write command (4'd0).
- After the write command it waits for the controller's done and reports completion.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, >= 2)
- AW, 4, FIFO pointer width; log2(DEPTH)
- CNT_W, 8, width of issued-command counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_cmd  in  4  command to enqueue
- in_valid  in  1  enqueue request
- in_ready  out  1  FIFO not full
- start  in  1  one-cycle pulse; begins issuing
- busy  in  1  controller busy
- done  in  1  controller done
- cmd  out  4  command to controller
- cmd_valid  out  1  command strobe, one cycle per command
- seq_done  out  1  sticky; controller reported done
- err_badcmd  out  1  sticky; a command > 11 was offered at load
- issued_cnt  out  CNT_W  commands issued since reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values:
  - cmd=0, cmd_valid=0, seq_done=0, err_badcmd=0, issued_cnt=0.
  - FIFO empty, so in_ready=1. State=LOAD.
- Enqueue: occurs when in_valid && in_ready.
  - Commands 0..11 are written to the FIFO.
  - Commands 12..15 are dropped and set err_badcmd. They are not written.
  - in_ready = !full, combinational from registered pointers.
  - Enqueue is permitted in every state except DONE.
- FIFO:
  - Circular buffer with AW+1-bit pointers; wrap-around is via the extra MSB.
  - full = (wr^rd)==DEPTH; empty = wr==rd.
  - Simultaneous enqueue and dequeue while full is not permitted (in_ready=0). Simultaneous enqueue and dequeue otherwise are both honoured.
- State machine:
  - LOAD: wait for start. A start while the FIFO is empty is still accepted. -> WAIT_RDY.
  - WAIT_RDY: wait for busy==0 and !empty. -> ISSUE.
  - ISSUE:
    - For exactly one cycle, cmd = FIFO head and cmd_valid=1; head is dequeued; issued_cnt += 1 (saturates at all-ones).
    - If the issued cmd == 0 -> WAIT_DONE, else -> GAP.
  - GAP: exactly one cycle with cmd_valid=0. -> WAIT_RDY.
    - This enforces at least 2 cycles between strobes, so the controller's busy reflects the previous command before the next is offered.
  - WAIT_DONE: cmd_valid=0. On done==1 -> DONE.
  - DONE: seq_done=1, held until reset. Enqueue is blocked (in_ready=0), and start is ignored.
- Output rules:
  - Whenever cmd_valid=0, cmd is driven to 4'd0. The controller executes the value on cmd even without cmd_valid; 0 is its only harmless idle value.
  - cmd and cmd_valid are registered outputs.
- Boundary conditions:
  - busy rising while in WAIT_RDY: hold; no strobe.
  - busy is sampled only in WAIT_RDY, never mid-ISSUE.
  - start during any state other than LOAD: ignored.
  - Commands following a 0 in the FIFO are never issued; they remain until reset.
  - Reset mid-operation returns everything to reset values within one cycle and flushes the FIFO.

Optional Feature:
- Macro: LCD_CMD_SEQ_AUTO_WRITE_EN.
- Defined: when in WAIT_RDY with busy==0, empty==1, and at least one command already issued, the sequencer issues a synthetic cmd 4'd0 via ISSUE. issued_cnt counts it, and the block proceeds to WAIT_DONE.
- Undefined: an empty FIFO simply stalls in WAIT_RDY until more commands are enqueued.

Test Plan:
- Reset, then load {1,4,7,0}, pulse start, busy held 1 for 70 cycles then 0 -> strobes cmd=1,4,7,0 with at least 2-cycle spacing, first strobe >= 1 cycle after busy falls; issued_cnt=4; done pulse -> seq_done=1.
- Load 16 commands -> in_ready=0 after the 16th; a 17th in_valid is not stored; drain restores in_ready=1; wrap-around order is preserved across a refill of 8 more.
- Offer in_cmd=13 and 15 -> err_badcmd=1, FIFO count unchanged, neither value ever appears on cmd.
- busy toggled 1 every other cycle during issue of {2,2,2,0} -> no strobe in any cycle following a busy=1 sample; cmd=0 whenever cmd_valid=0.
- Load {3}, start, busy=0 -> with macro: strobes 3 then 0, issued_cnt=2; without: strobe 3 then stall, cmd_valid=0 for 50 cycles; enqueue 0 -> strobe 0.
- Reset asserted in WAIT_DONE -> next cycle all outputs at reset values, in_ready=1, a start with an empty FIFO produces no strobe.
